// File: rtl/controle_pkg.sv
// Shared definitions for the control unit: field widths, opcodes, ALU codes,
// FSM state encoding and the instruction word layout.
package controle_pkg;

    localparam int unsigned LARG_OPC = 4;
    localparam int unsigned LARG_REG = 2;
    localparam int unsigned LARG_ULA = 3;

    // Opcodes
    localparam logic [LARG_OPC-1:0] OPC_NOP = 4'h0;
    localparam logic [LARG_OPC-1:0] OPC_ADD = 4'h1;
    localparam logic [LARG_OPC-1:0] OPC_SUB = 4'h2;
    localparam logic [LARG_OPC-1:0] OPC_AND = 4'h3;
    localparam logic [LARG_OPC-1:0] OPC_OR  = 4'h4;
    localparam logic [LARG_OPC-1:0] OPC_MOV = 4'h5;
    localparam logic [LARG_OPC-1:0] OPC_JZ  = 4'h6;

    // ALU operation codes
    localparam logic [LARG_ULA-1:0] ULA_ADD   = 3'b000;
    localparam logic [LARG_ULA-1:0] ULA_SUB   = 3'b001;
    localparam logic [LARG_ULA-1:0] ULA_AND   = 3'b010;
    localparam logic [LARG_ULA-1:0] ULA_OR    = 3'b011;
    localparam logic [LARG_ULA-1:0] ULA_PASSB = 3'b100;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        DECOD  = 3'd1,
        LEIT   = 3'd2,
        EXEC   = 3'd3,
        ESCR   = 3'd4
    } estado_t;

    typedef struct packed {
        logic [LARG_OPC-1:0] opc;
        logic [LARG_REG-1:0] rd;
        logic [LARG_REG-1:0] rs;
    } instr_t;

endpackage

// File: rtl/decodificador_opc.sv
// Opcode decoder: maps an opcode to the ALU operation and the write / branch /
// invalid-opcode flags. Purely combinational.
//   opc_i      : opcode field of the instruction register
//   op_ula_o   : ALU operation
//   escreve_o  : instruction writes the register file
//   salto_o    : instruction is a conditional branch (JZ)
//   invalido_o : opcode outside the defined set (executes as NOP)
module decodificador_opc
    import controle_pkg::*;
(
    input  logic [LARG_OPC-1:0] opc_i,
    output logic [LARG_ULA-1:0] op_ula_o,
    output logic                escreve_o,
    output logic                salto_o,
    output logic                invalido_o
);

    always_comb begin
        op_ula_o   = ULA_ADD;
        escreve_o  = 1'b0;
        salto_o    = 1'b0;
        invalido_o = 1'b0;
        case (opc_i)
            OPC_NOP: ;
            OPC_ADD: begin op_ula_o = ULA_ADD;   escreve_o = 1'b1; end
            OPC_SUB: begin op_ula_o = ULA_SUB;   escreve_o = 1'b1; end
            OPC_AND: begin op_ula_o = ULA_AND;   escreve_o = 1'b1; end
            OPC_OR:  begin op_ula_o = ULA_OR;    escreve_o = 1'b1; end
            OPC_MOV: begin op_ula_o = ULA_PASSB; escreve_o = 1'b1; end
            OPC_JZ:  salto_o = 1'b1;
            default: invalido_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: OCIOSO -> DECOD -> LEIT -> EXEC -> ESCR, one
// instruction per 5 cycles. All outputs are registered and derived from the
// next state and instruction register, so no input reaches an output
// combinationally.
// Optional feature: define CONTA_INSTR_EN to count retired instructions on
// NumInstr; otherwise NumInstr is tied to 0.
//   Clk, Reset          : clock, asynchronous active-high reset
//   Instr, InstrValida  : instruction word and its valid strobe
//   Zero                : ALU zero flag (sampled at the end of EXEC for JZ)
//   Fonte1, Fonte2      : register-file read selects (rd, rs)
//   RegEsc, Esc         : register-file write select and enable
//   OpULA               : ALU operation
//   Ocupado             : busy
//   Pronto              : done pulse in ESCR
//   CarregaPC           : branch-taken pulse in ESCR
//   ErroOpc             : invalid-opcode pulse in ESCR
//   NumInstr            : retired-instruction count
module unidade_controle
    import controle_pkg::*;
#(
    parameter int unsigned LARG_CONT = 16
)
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [7:0]           Instr,
    input  logic                 InstrValida,
    input  logic                 Zero,
    output logic [1:0]           Fonte1,
    output logic [1:0]           Fonte2,
    output logic [1:0]           RegEsc,
    output logic                 Esc,
    output logic [2:0]           OpULA,
    output logic                 Ocupado,
    output logic                 Pronto,
    output logic                 CarregaPC,
    output logic                 ErroOpc,
    output logic [LARG_CONT-1:0] NumInstr
);

    estado_t estado_q, estado_d;
    instr_t  ir_q, ir_d;

    logic [LARG_REG-1:0] fonte1_q, fonte1_d;
    logic [LARG_REG-1:0] fonte2_q, fonte2_d;
    logic [LARG_REG-1:0] reg_esc_q, reg_esc_d;
    logic [LARG_ULA-1:0] op_ula_q, op_ula_d;
    logic                esc_q, esc_d;
    logic                ocupado_q, ocupado_d;
    logic                pronto_q, pronto_d;
    logic                carrega_pc_q, carrega_pc_d;
    logic                erro_opc_q, erro_opc_d;

    logic [LARG_ULA-1:0] dec_op_ula;
    logic                dec_escreve;
    logic                dec_salto;
    logic                dec_invalido;

    // IR is stable from DECOD onward, so decoding the registered IR suffices
    decodificador_opc u_decod (
        .opc_i      (ir_q.opc),
        .op_ula_o   (dec_op_ula),
        .escreve_o  (dec_escreve),
        .salto_o    (dec_salto),
        .invalido_o (dec_invalido)
    );

    // Next state, IR capture, and next values of the registered outputs
    always_comb begin
        estado_d     = estado_q;
        ir_d         = ir_q;
        fonte1_d     = '0;
        fonte2_d     = '0;
        reg_esc_d    = '0;
        op_ula_d     = '0;
        esc_d        = 1'b0;
        ocupado_d    = 1'b0;
        pronto_d     = 1'b0;
        carrega_pc_d = 1'b0;
        erro_opc_d   = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (InstrValida) begin
                    ir_d     = instr_t'(Instr);
                    estado_d = DECOD;
                end
            end
            DECOD:   estado_d = LEIT;
            LEIT:    estado_d = EXEC;
            EXEC:    estado_d = ESCR;
            ESCR:    estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase

        if (estado_d != OCIOSO) begin
            ocupado_d = 1'b1;
            fonte1_d  = ir_d.rd;
            fonte2_d  = ir_d.rs;
        end

        if (estado_d == EXEC || estado_d == ESCR) begin
            op_ula_d = dec_op_ula;
        end

        // ESCR is only entered from EXEC, so Zero here is the end-of-EXEC sample
        if (estado_d == ESCR) begin
            pronto_d     = 1'b1;
            esc_d        = dec_escreve;
            reg_esc_d    = dec_escreve ? ir_d.rd : '0;
            carrega_pc_d = dec_salto & Zero;
            erro_opc_d   = dec_invalido;
        end
    end

    // State, IR and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            estado_q     <= OCIOSO;
            ir_q         <= '0;
            fonte1_q     <= '0;
            fonte2_q     <= '0;
            reg_esc_q    <= '0;
            op_ula_q     <= '0;
            esc_q        <= 1'b0;
            ocupado_q    <= 1'b0;
            pronto_q     <= 1'b0;
            carrega_pc_q <= 1'b0;
            erro_opc_q   <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            ir_q         <= ir_d;
            fonte1_q     <= fonte1_d;
            fonte2_q     <= fonte2_d;
            reg_esc_q    <= reg_esc_d;
            op_ula_q     <= op_ula_d;
            esc_q        <= esc_d;
            ocupado_q    <= ocupado_d;
            pronto_q     <= pronto_d;
            carrega_pc_q <= carrega_pc_d;
            erro_opc_q   <= erro_opc_d;
        end
    end

    assign Fonte1    = fonte1_q;
    assign Fonte2    = fonte2_q;
    assign RegEsc    = reg_esc_q;
    assign Esc       = esc_q;
    assign OpULA     = op_ula_q;
    assign Ocupado   = ocupado_q;
    assign Pronto    = pronto_q;
    assign CarregaPC = carrega_pc_q;
    assign ErroOpc   = erro_opc_q;

`ifdef CONTA_INSTR_EN
    logic [LARG_CONT-1:0] num_instr_q;

    // Retire count advances on the edge that leaves ESCR; wraps naturally
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            num_instr_q <= '0;
        end else if (estado_q == ESCR) begin
            num_instr_q <= num_instr_q + LARG_CONT'(1);
        end
    end

    assign NumInstr = num_instr_q;
`else
    assign NumInstr = '0;
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle (LARG_CONT=2). Expected ESCR-cycle
// results are queued when an instruction is issued and compared when Pronto
// appears; per-cycle sequencing is checked directly around each issue.
`timescale 1ns/1ps
module tb_unidade_controle;

    localparam int unsigned LARG_CONT = 2;

    logic                 Clk;
    logic                 Reset;
    logic [7:0]           Instr;
    logic                 InstrValida;
    logic                 Zero;
    logic [1:0]           Fonte1;
    logic [1:0]           Fonte2;
    logic [1:0]           RegEsc;
    logic                 Esc;
    logic [2:0]           OpULA;
    logic                 Ocupado;
    logic                 Pronto;
    logic                 CarregaPC;
    logic                 ErroOpc;
    logic [LARG_CONT-1:0] NumInstr;

    unidade_controle #(.LARG_CONT(LARG_CONT)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Instr       (Instr),
        .InstrValida (InstrValida),
        .Zero        (Zero),
        .Fonte1      (Fonte1),
        .Fonte2      (Fonte2),
        .RegEsc      (RegEsc),
        .Esc         (Esc),
        .OpULA       (OpULA),
        .Ocupado     (Ocupado),
        .Pronto      (Pronto),
        .CarregaPC   (CarregaPC),
        .ErroOpc     (ErroOpc),
        .NumInstr    (NumInstr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       esc;
        logic [1:0] reg_esc;
        logic       carrega;
        logic       erro;
        logic [2:0] op;
        logic [1:0] f1;
        logic [1:0] f2;
    } esper_t;

    esper_t sb[$];
    int n_chk;
    int n_fail;
    int n_pronto;
    int base_pronto;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_chk++;
        if (obs !== esp) begin
            n_fail++;
            $display("FAIL %s: obtido=%0h esperado=%0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    // Independent reference for what ESCR must show for a given instruction
    function automatic esper_t modelo(input logic [7:0] ins, input logic z);
        esper_t e;
        logic [3:0] opc;
        e    = '0;
        opc  = ins[7:4];
        e.f1 = ins[3:2];
        e.f2 = ins[1:0];
        case (opc)
            4'h0: ;
            4'h1: begin e.op = 3'b000; e.esc = 1'b1; end
            4'h2: begin e.op = 3'b001; e.esc = 1'b1; end
            4'h3: begin e.op = 3'b010; e.esc = 1'b1; end
            4'h4: begin e.op = 3'b011; e.esc = 1'b1; end
            4'h5: begin e.op = 3'b100; e.esc = 1'b1; end
            4'h6: e.carrega = z;
            default: e.erro = 1'b1;
        endcase
        if (e.esc) e.reg_esc = ins[3:2];
        return e;
    endfunction

    function automatic logic [31:0] cnt_esp();
`ifdef CONTA_INSTR_EN
        return 32'(LARG_CONT'(n_pronto - base_pronto));
`else
        return 32'd0;
`endif
    endfunction

    // Scoreboard consumer: compare ESCR outputs on Pronto, and require the
    // ESCR-only pulses to stay low everywhere else
    always @(negedge Clk) begin
        esper_t e;
        if (Reset) begin
            sb.delete();
        end else if (Pronto) begin
            n_pronto++;
            if (sb.size() == 0) begin
                verifica("pronto_inesperado", 32'(Pronto), 32'd0);
            end else begin
                e = sb.pop_front();
                verifica("sb_esc",     32'(Esc),       32'(e.esc));
                verifica("sb_regesc",  32'(RegEsc),    32'(e.reg_esc));
                verifica("sb_carrega", 32'(CarregaPC), 32'(e.carrega));
                verifica("sb_erro",    32'(ErroOpc),   32'(e.erro));
                verifica("sb_opula",   32'(OpULA),     32'(e.op));
                verifica("sb_fonte1",  32'(Fonte1),    32'(e.f1));
                verifica("sb_fonte2",  32'(Fonte2),    32'(e.f2));
            end
        end else begin
            verifica("fora_escr", 32'({Esc, CarregaPC, ErroOpc, RegEsc}), 32'd0);
        end
    end

    // Issue one instruction and check cycles 1..5; optionally pulse
    // InstrValida with a different word during LEIT
    task automatic executa(input logic [7:0] ins, input logic z, input logic pulso);
        esper_t e;
        e = modelo(ins, z);
        @(negedge Clk);
        Instr       = ins;
        InstrValida = 1'b1;
        Zero        = ~z;
        sb.push_back(e);
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clk);
            verifica("ocupado", 32'(Ocupado), 32'd1);
            verifica("fonte1",  32'(Fonte1),  32'(e.f1));
            verifica("fonte2",  32'(Fonte2),  32'(e.f2));
            verifica("opula",   32'(OpULA),   (c >= 3) ? 32'(e.op) : 32'd0);
            verifica("esc",     32'(Esc),     (c == 4) ? 32'(e.esc) : 32'd0);
            verifica("pronto",  32'(Pronto),  (c == 4) ? 32'd1 : 32'd0);
            InstrValida = pulso && (c == 2);
            if (pulso && c == 2) Instr = 8'h5F;
            Zero = (c == 3) ? z : ~z;
        end
        @(negedge Clk);
        verifica("ocioso",    32'(Ocupado),  32'd0);
        verifica("num_instr", 32'(NumInstr), cnt_esp());
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        n_pronto    = 0;
        base_pronto = 0;
        Reset       = 1'b1;
        Instr       = 8'h29;
        InstrValida = 1'b1;
        Zero        = 1'b0;

        // Reset state, with a valid instruction already waiting
        @(negedge Clk);
        verifica("rst_saidas", 32'({Fonte1, Fonte2, RegEsc, Esc, OpULA, Ocupado,
                                    Pronto, CarregaPC, ErroOpc}), 32'd0);
        verifica("rst_num", 32'(NumInstr), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        base_pronto = n_pronto;
        sb.push_back(modelo(8'h29, 1'b0));
        @(negedge Clk);
        verifica("pos_reset_aceita", 32'(Ocupado), 32'd1);
        InstrValida = 1'b0;
        repeat (4) @(negedge Clk);

        // Write sequencing and every defined opcode
        executa(8'h1E, 1'b0, 1'b0);
        executa(8'h29, 1'b0, 1'b0);
        executa(8'h37, 1'b0, 1'b0);
        executa(8'h4C, 1'b0, 1'b0);
        executa(8'h5B, 1'b0, 1'b0);
        executa(8'h00, 1'b0, 1'b0);
        // JZ taken / not taken
        executa(8'h60, 1'b1, 1'b0);
        executa(8'h60, 1'b0, 1'b0);
        // Invalid opcodes, with a busy-time InstrValida pulse
        executa(8'hF0, 1'b0, 1'b1);
        executa(8'h76, 1'b1, 1'b0);
        executa(8'h19, 1'b0, 1'b1);

        // Reset mid-LEIT abandons the instruction
        sb.push_back(modelo(8'h1E, 1'b0));
        @(negedge Clk);
        Instr       = 8'h1E;
        InstrValida = 1'b1;
        @(negedge Clk);
        InstrValida = 1'b0;
        @(negedge Clk);
        verifica("ocupado_leit", 32'(Ocupado), 32'd1);
        #2 Reset = 1'b1;
        #1;
        verifica("rst_meio_saidas", 32'({Fonte1, Fonte2, RegEsc, Esc, OpULA, Ocupado,
                                         Pronto, CarregaPC, ErroOpc}), 32'd0);
        verifica("rst_meio_num", 32'(NumInstr), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        base_pronto = n_pronto;
        repeat (8) begin
            @(negedge Clk);
            verifica("rst_sem_pronto", 32'(Pronto), 32'd0);
            verifica("rst_sem_esc",    32'(Esc),    32'd0);
        end

        // Back-to-back issue with InstrValida held; counter wraps at 4
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        base_pronto = n_pronto;
        for (int i = 0; i < 5; i++) sb.push_back(modelo(8'h1E, 1'b0));
        @(negedge Clk);
        Instr       = 8'h1E;
        InstrValida = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge Clk);
            if (c == 21) InstrValida = 1'b0;
            verifica("b2b_pronto", 32'(Pronto), (c % 5 == 4) ? 32'd1 : 32'd0);
        end
`ifdef CONTA_INSTR_EN
        verifica("num_wrap", 32'(NumInstr), 32'd1);
`else
        verifica("num_zero", 32'(NumInstr), 32'd0);
`endif
        verifica("num_modelo", 32'(NumInstr), cnt_esp());

        verifica("sb_pendente", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
